// File: rtl/jt49_ctl_pkg.sv
// Shared encodings for the JT49 bus scheduler: FSM states and the {bdir,bc1} pin codes.
package jt49_ctl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    GAP1 = 3'd2,
    XFER = 3'd3,
    GAP2 = 3'd4,
    ACK  = 3'd5
  } state_t;

  localparam logic [1:0] INACT = 2'b00;
  localparam logic [1:0] READ  = 2'b01;
  localparam logic [1:0] WRITE = 2'b10;
  localparam logic [1:0] LATCH = 2'b11;

  // Pin code presented while the FSM sits in a given state.
  function automatic logic [1:0] pins_for(input state_t st, input logic wr);
    case (st)
      ADDR:    return LATCH;
      XFER:    return wr ? WRITE : READ;
      default: return INACT;
    endcase
  endfunction

endpackage

// File: rtl/jt49_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, pointer updated on advance.
module jt49_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // prio1 set means requester 1 wins a tie; cleared so requester 0 wins first.
  logic prio1;

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = prio1 ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   prio1 <= 1'b0;
    else if (advance && |grant) prio1 <= grant[0];
  end

endmodule

// File: rtl/jt49_bus_sched.sv
// Serialises two requesters onto the AY/YM PSG BDIR/BC1 bus: latch address, gap,
// data transfer (write or read), gap, then a one-cycle ack to the granted requester.
module jt49_bus_sched
  import jt49_ctl_pkg::*;
#(
  parameter int HOLD   = 2,
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [7:0]  addr,
  input  logic [15:0] wdata,
  output logic [1:0]  ack,
  output logic [7:0]  rdata,
  output logic        bdir,
  output logic        bc1,
  output logic [7:0]  bus_dout,
  input  logic [7:0]  psg_din,
  output logic        busy
);

  localparam logic [3:0] WR_LEN = 4'(HOLD - 1);
  localparam logic [3:0] RD_LEN = 4'(HOLD + RD_LAT - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [1:0] grant;
  logic       start, sel;
  logic       gnt, we_q;
  logic [7:0] wdata_q;
  logic [3:0] addr_sel;

  assign start    = (state == IDLE) && |req;
  assign sel      = grant[1];
  assign addr_sel = sel ? addr[7:4] : addr[3:0];
  assign busy     = (state != IDLE);

  jt49_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (start),
    .grant   (grant)
  );

  // Each phase loads cnt with its length minus one and leaves when cnt hits zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (start) begin
        state_nxt = ADDR;
        cnt_nxt   = WR_LEN;
      end
      ADDR: if (cnt == 4'd0) begin
        state_nxt = GAP1;
        cnt_nxt   = 4'd0;
      end else cnt_nxt = cnt - 4'd1;
      GAP1: begin
        state_nxt = XFER;
        cnt_nxt   = we_q ? WR_LEN : RD_LEN;
      end
      XFER: if (cnt == 4'd0) begin
        state_nxt = GAP2;
        cnt_nxt   = 4'd0;
      end else cnt_nxt = cnt - 4'd1;
      GAP2: begin
        state_nxt = ACK;
        cnt_nxt   = 4'd0;
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pins and ack are decoded from the next state so they line up with the state cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      gnt        <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= 8'h00;
      {bdir,bc1} <= INACT;
      bus_dout   <= 8'h00;
      ack        <= 2'b00;
      rdata      <= 8'h00;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      {bdir,bc1} <= pins_for(state_nxt, we_q);
      ack        <= (state_nxt == ACK) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
      if (start) begin
        gnt      <= sel;
        we_q     <= we[sel];
        wdata_q  <= sel ? wdata[15:8] : wdata[7:0];
        bus_dout <= {4'h0, addr_sel};
      end
      if (state == GAP1 && we_q) bus_dout <= wdata_q;
      if (state == XFER && !we_q && cnt == 4'd0) rdata <= psg_din;
    end
  end

endmodule

// File: tb/tb_jt49_bus_sched.sv
// Bench for jt49_bus_sched: directed bus traces plus a cycle model of the transaction timeline.
module tb_jt49_bus_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req = '0, we = '0;
  logic [7:0]  addr = '0, psg_din = '0;
  logic [15:0] wdata = '0;

  logic [1:0] a_ack, b_ack;
  logic [7:0] a_rdata, b_rdata, a_dout, b_dout;
  logic       a_bdir, a_bc1, a_busy, b_bdir, b_bc1, b_busy;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [1:0] ackq[$];

  always #5 clk = ~clk;

  jt49_bus_sched #(.HOLD(2), .RD_LAT(2)) u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(a_ack), .rdata(a_rdata), .bdir(a_bdir), .bc1(a_bc1), .bus_dout(a_dout),
    .psg_din(psg_din), .busy(a_busy)
  );

  jt49_bus_sched #(.HOLD(1), .RD_LAT(0)) u_fast (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(b_ack), .rdata(b_rdata), .bdir(b_bdir), .bc1(b_bc1), .bus_dout(b_dout),
    .psg_din(psg_din), .busy(b_busy)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; psg_din = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req = 2'b11; we = 2'b11;
    #1;
    n_cmp++;
    if ({a_bdir,a_bc1,a_dout,a_ack,a_rdata,a_busy} !== 21'd0) begin
      n_fail++; $display("FAIL reset_async: got %h want 0", {a_bdir,a_bc1,a_dout,a_ack,a_rdata,a_busy});
    end
    @(negedge clk);
    n_cmp++;
    if ({a_bdir,a_bc1,a_dout,a_ack,a_rdata,a_busy,b_bdir,b_bc1,b_ack,b_busy} !== 27'd0) begin
      n_fail++; $display("FAIL reset_held: got %h %h want 0",
                         {a_bdir,a_bc1,a_dout,a_ack,a_rdata,a_busy}, {b_bdir,b_bc1,b_ack,b_busy});
    end
    rst = 1'b0; req = '0; we = '0;
  endtask

  task automatic test_single_write_read();
    logic [11:0] ev;
    do_reset();
    req = 2'b01; we = 2'b01; addr = 8'h07; wdata = 16'h0038;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      case (c)
        1, 2:    ev = {2'b11, 8'h07, 2'b00};
        3:       ev = {2'b00, 8'h07, 2'b00};
        4, 5:    ev = {2'b10, 8'h38, 2'b00};
        6:       ev = {2'b00, 8'h38, 2'b00};
        default: ev = {2'b00, 8'h38, 2'b01};
      endcase
      n_cmp++;
      if ({a_bdir,a_bc1,a_dout,a_ack} !== ev) begin
        n_fail++; $display("FAIL write_trace cyc%0d: got %h want %h", c, {a_bdir,a_bc1,a_dout,a_ack}, ev);
      end
      if (c == 7) req = 2'b00;
    end
    @(negedge clk);
    n_cmp++;
    if ({a_busy,a_ack} !== 3'b000) begin
      n_fail++; $display("FAIL write_idle: got busy/ack %b want 000", {a_busy,a_ack});
    end
    req = 2'b10; we = 2'b00; addr = 8'hE0; psg_din = 8'hA5;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      case (c)
        1, 2:       ev = {2'b11, 8'h0E, 2'b00};
        3, 8:       ev = {2'b00, 8'h0E, 2'b00};
        4, 5, 6, 7: ev = {2'b01, 8'h0E, 2'b00};
        default:    ev = {2'b00, 8'h0E, 2'b10};
      endcase
      n_cmp++;
      if ({a_bdir,a_bc1,a_dout,a_ack} !== ev) begin
        n_fail++; $display("FAIL read_trace cyc%0d: got %h want %h", c, {a_bdir,a_bc1,a_dout,a_ack}, ev);
      end
      if (c == 9) begin
        n_cmp++;
        if (a_rdata !== 8'hA5) begin
          n_fail++; $display("FAIL read_data: got %h want a5", a_rdata);
        end
        req = 2'b00;
      end
    end
    @(negedge clk);
    psg_din = 8'h3C; req = 2'b01; we = 2'b01; addr = 8'h03; wdata = 16'h005A;
    for (int c = 1; c <= 7; c++) @(negedge clk);
    n_cmp++;
    if ({a_ack,a_rdata} !== {2'b01, 8'hA5}) begin
      n_fail++; $display("FAIL rdata_hold: got ack/rdata %h want 1a5", {a_ack,a_rdata});
    end
    req = 2'b00;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 2'b01; we = 2'b01; addr = 8'h02; wdata = 16'h0077;
    for (int c = 1; c <= 4; c++) @(negedge clk);
    n_cmp++;
    if ({a_bdir,a_bc1,a_dout} !== {2'b10, 8'h77}) begin
      n_fail++; $display("FAIL midrst_pre: got %h want 277", {a_bdir,a_bc1,a_dout});
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({a_bdir,a_bc1,a_ack,a_busy} !== 5'd0) begin
      n_fail++; $display("FAIL midrst_async: got %b want 00000", {a_bdir,a_bc1,a_ack,a_busy});
    end
    req = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({a_ack,a_busy} !== 3'b000) begin
        n_fail++; $display("FAIL midrst_noretry cyc%0d: got %b want 000", c, {a_ack,a_busy});
      end
    end
    req = 2'b11; we = 2'b11; addr = 8'h21; wdata = 16'h1122;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      n_cmp++;
      if (a_ack !== ((c == 7) ? 2'b01 : 2'b00)) begin
        n_fail++; $display("FAIL midrst_regrant cyc%0d: got %b want %b", c, a_ack, (c == 7) ? 2'b01 : 2'b00);
      end
    end
    req = 2'b00;
  endtask

  // Transaction-level model: each grant plays out a fixed phase timeline.
  task automatic run_model(input bit sel, input int hold, input int lat, input int ncyc,
                           input int p_raise, input bit rd_only, input string name);
    bit         active = 1'b0, gw = 1'b0, g = 1'b0, lastg = 1'b1, done_now;
    int         ph = 0, lastx = 0, total = 0;
    logic [3:0] gaddr = '0;
    logic [7:0] gdata = '0, exp_dout = '0, exp_rdata = '0;
    logic [1:0] exp_pins, exp_ack;
    logic [20:0] obs, ev;
    ackq.delete();
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      exp_pins = 2'b00; exp_ack = 2'b00;
      if (active) begin
        if (ph <= hold) begin
          exp_pins = 2'b11; exp_dout = {4'h0, gaddr};
        end else if (ph >= hold + 2 && ph <= lastx) begin
          exp_pins = gw ? 2'b10 : 2'b01;
          if (gw) exp_dout = gdata;
        end else if (ph == total) exp_ack = g ? 2'b10 : 2'b01;
      end
      ev  = {exp_pins, exp_dout, exp_ack, active, exp_rdata};
      obs = sel ? {b_bdir,b_bc1,b_dout,b_ack,b_busy,b_rdata} : {a_bdir,a_bc1,a_dout,a_ack,a_busy,a_rdata};
      n_cmp++;
      if (obs !== ev) begin
        n_fail++; $display("FAIL %s cyc%0d: got %h want %h", name, c, obs, ev);
      end
      if (obs[10:9] != 2'b00) ackq.push_back(obs[10:9]);
      done_now = active && (ph == total);
      if (done_now) req[g] = 1'b0;
      for (int n = 0; n < 2; n++) begin
        we[n] = rd_only ? 1'b0 : 1'($urandom);
        addr[4*n +: 4]  = 4'($urandom);
        wdata[8*n +: 8] = 8'($urandom);
        if (!req[n] && $urandom_range(99) < p_raise) req[n] = 1'b1;
      end
      psg_din = 8'($urandom);
      if (active && !gw && ph == lastx) exp_rdata = psg_din;
      if (done_now) active = 1'b0;
      else if (active) ph++;
      else if (|req) begin
        g      = (req == 2'b11) ? ~lastg : req[1];
        lastg  = g;
        gw     = we[g];
        gaddr  = addr[4*g +: 4];
        gdata  = wdata[8*g +: 8];
        lastx  = hold + 1 + (gw ? hold : hold + lat);
        total  = lastx + 2;
        ph     = 1;
        active = 1'b1;
      end
    end
    req = 2'b00;
  endtask

  task automatic test_round_robin();
    logic [1:0] want;
    run_model(1'b0, 2, 2, 60, 100, 1'b0, "rr");
    n_cmp++;
    if (ackq.size() < 4) begin
      n_fail++; $display("FAIL rr_count: got %0d acks want >=4", ackq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        want = (i % 2 == 1) ? 2'b10 : 2'b01;
        n_cmp++;
        if (ackq[i] !== want) begin
          n_fail++; $display("FAIL rr_order #%0d: got %b want %b", i, ackq[i], want);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    run_model(1'b1, 1, 0, 40, 100, 1'b1, "b2b_fast");
  endtask

  task automatic test_random();
    run_model(1'b0, 2, 2, 400, 35, 1'b0, "rand_dflt");
    run_model(1'b1, 1, 0, 200, 35, 1'b0, "rand_fast");
  endtask

  initial begin
    test_reset();
    test_single_write_read();
    test_reset_mid();
    test_round_robin();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
